seg7_scan: RTL and testbench

- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display; successor to the single-digit hex decoder.
- Latches a packed hex value through a load strobe and scans one digit per SCAN_DIV clocks.
- Commits new values only at frame boundaries (no tearing); provides leading-zero suppression, per-digit blanking and per-digit blinking.
- Sits between debug/status registers and the board display pins.

---
 rtl/seg7_scan.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Time-multiplexed driver for a DIGITS-wide common-anode 7-segment
//            display. Latches a packed hex value, commits it only at frame
//            boundaries, scans one digit per SCAN_DIV clocks, and supports
//            leading-zero suppression, per-digit blanking and blinking.
//            Optional decimal points: define SEG7_SCAN_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [4*DIGITS-1:0]   idat,
  input  logic                  load,
  input  logic                  lzs_en,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
`ifdef SEG7_SCAN_DP_EN
  input  logic [DIGITS-1:0]     dp,
  output logic                  odp,
`endif
  output logic [6:0]            odat,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int c_PW = $clog2(SCAN_DIV);
  localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_PW-1:0]   c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
  localparam logic [c_IW-1:0]   c_IDX_LAST   = c_IW'(DIGITS - 1);
  localparam logic [c_BW-1:0]   c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] c_AN_ONE     = DIGITS'(1);

  logic [c_PW-1:0]     r_presc;
  logic [c_IW-1:0]     r_idx;
  logic [c_BW-1:0]     r_blink;
  logic                r_phase;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_pvalid;
  logic [4*DIGITS-1:0] r_disp;
`ifdef SEG7_SCAN_DP_EN
  logic [DIGITS-1:0]   r_pend_dp;
  logic [DIGITS-1:0]   r_disp_dp;
`endif

  logic                w_presc_tc;
  logic                w_wrap;
  logic [DIGITS-1:0]   w_lz_run;
  logic                w_run;
  logic [3:0]          w_digit;
  logic                w_blank;

  // Active-low gfedcba glyph for one hex nibble
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    f_glyph = 7'b1000000;
      4'h1:    f_glyph = 7'b1111001;
      4'h2:    f_glyph = 7'b0100100;
      4'h3:    f_glyph = 7'b0110000;
      4'h4:    f_glyph = 7'b0011001;
      4'h5:    f_glyph = 7'b0010010;
      4'h6:    f_glyph = 7'b0000010;
      4'h7:    f_glyph = 7'b1011000;
      4'h8:    f_glyph = 7'b0000000;
      4'h9:    f_glyph = 7'b0010000;
      4'hA:    f_glyph = 7'b0001000;
      4'hB:    f_glyph = 7'b0000011;
      4'hC:    f_glyph = 7'b1000110;
      4'hD:    f_glyph = 7'b0100001;
      4'hE:    f_glyph = 7'b0000110;
      default: f_glyph = 7'b0001110;
    endcase
  endfunction

  // Frame boundary: last clock of the last digit's slot
  assign w_presc_tc = (r_presc == c_PRESC_LAST);
  assign w_wrap     = w_presc_tc && (r_idx == c_IDX_LAST);
  assign frame      = w_wrap;

  // Prescaler and digit index
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Blink frame counter; phase toggles every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_blink <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink == c_BLINK_LAST) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + 1'b1;
      end
    end
  end

  // Pending/display double buffer; a load coinciding with the boundary bypasses pending
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pend    <= '0;
      r_pvalid  <= 1'b0;
      r_disp    <= '0;
`ifdef SEG7_SCAN_DP_EN
      r_pend_dp <= '0;
      r_disp_dp <= '0;
`endif
    end else if (w_wrap) begin
      if (load) begin
        r_disp    <= idat;
`ifdef SEG7_SCAN_DP_EN
        r_disp_dp <= dp;
`endif
      end else if (r_pvalid) begin
        r_disp    <= r_pend;
`ifdef SEG7_SCAN_DP_EN
        r_disp_dp <= r_pend_dp;
`endif
      end
      r_pvalid <= 1'b0;
    end else if (load) begin
      r_pend    <= idat;
      r_pvalid  <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
      r_pend_dp <= dp;
`endif
    end
  end

  // w_lz_run[k] = digits k..DIGITS-1 are all zero (and carry no decimal point)
  always_comb begin
    w_lz_run = '0;
    w_run    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef SEG7_SCAN_DP_EN
      w_run = w_run && (r_disp[4*k +: 4] == 4'h0) && !r_disp_dp[k];
`else
      w_run = w_run && (r_disp[4*k +: 4] == 4'h0);
`endif
      w_lz_run[k] = w_run;
    end
  end

  assign w_digit = r_disp[{r_idx, 2'b00} +: 4];
  assign w_blank = blank_mask[r_idx]
                 | (blink_mask[r_idx] & r_phase)
                 | (lzs_en & (r_idx != '0) & w_lz_run[r_idx]);

  // Registered segment/anode drive for the digit currently selected
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      odat <= 7'h7F;
      an   <= '1;
`ifdef SEG7_SCAN_DP_EN
      odp  <= 1'b1;
`endif
    end else if (w_blank) begin
      odat <= 7'h7F;
      an   <= '1;
`ifdef SEG7_SCAN_DP_EN
      odp  <= 1'b1;
`endif
    end else begin
      odat <= f_glyph(w_digit);
      an   <= ~(c_AN_ONE << r_idx);
`ifdef SEG7_SCAN_DP_EN
      odp  <= ~r_disp_dp[r_idx];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Brief    : Randomized scoreboard bench for seg7_scan (DIGITS=4, SCAN_DIV=4,
//            BLINK_FRAMES=2) against a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

  logic        clk;
  logic        n_rst;
  logic [15:0] idat;
  logic        load;
  logic        lzs_en;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  odat;
  logic [3:0]  an;
  logic        frame;
`ifdef SEG7_SCAN_DP_EN
  logic [3:0]  dp;
  logic        odp;
`endif

  seg7_scan #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .idat       (idat),
    .load       (load),
    .lzs_en     (lzs_en),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
`ifdef SEG7_SCAN_DP_EN
    .dp         (dp),
    .odp        (odp),
`endif
    .odat       (odat),
    .an         (an),
    .frame      (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [6:0] odat;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t q[$];

  // Reference model state: cycles since reset release, display, pending value
  int          m_c    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv   = 1'b0;
  int          m_idx;
  int          m_fno;
  bit          m_phase;
  bit          m_blank;
  bit          m_bound;
  exp_t        m_e;

  // Model: from the cycle count derive digit slot, frame number and blink phase
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q.delete();
      m_c    = 0;
      m_disp = '0;
      m_pend = '0;
      m_pv   = 1'b0;
    end else begin
      m_idx   = (m_c / SCAN_DIV) % DIGITS;
      m_fno   = m_c / FRAME_LEN;
      m_phase = ((m_fno / BLINK_FRAMES) % 2) == 1;
      m_bound = (m_c % FRAME_LEN) == FRAME_LEN - 1;
      m_blank = blank_mask[m_idx]
             || (blink_mask[m_idx] && m_phase)
             || (lzs_en && m_idx != 0 && (m_disp >> (4 * m_idx)) == 16'h0);
      if (m_blank) begin
        m_e.odat = 7'h7F;
        m_e.an   = 4'hF;
      end else begin
        m_e.odat = GLYPH[(m_disp >> (4 * m_idx)) & 16'hF];
        m_e.an   = ~(4'(1) << m_idx);
      end
      m_e.frame = ((m_c + 1) % FRAME_LEN) == FRAME_LEN - 1;
      q.push_back(m_e);
      if (m_bound) begin
        if (load)      m_disp = idat;
        else if (m_pv) m_disp = m_pend;
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = idat;
        m_pv   = 1'b1;
      end
      m_c++;
    end
  end

  // Monitor: each cycle the DUT presents a new output word; compare with the queue head
  exp_t mon_e;
  always @(negedge clk) begin
    if (n_rst && q.size() != 0) begin
      mon_e = q.pop_front();
      n_vec++;
      if ({odat, an, frame} !== mon_e) begin
        n_err++;
        $display("FAIL scan @%0t: odat=%b an=%b frame=%b, expected odat=%b an=%b frame=%b",
                 $time, odat, an, frame, mon_e.odat, mon_e.an, mon_e.frame);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns at posedge+1 of a cycle in which frame is high
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      @(posedge clk);
      #1;
      if (frame) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: no frame pulse within %0d cycles", 4 * FRAME_LEN);
    end
  endtask

  logic [15:0] zmask;
  bit          got_frame;

  initial begin
    n_rst      = 1'b0;
    idat       = '0;
    load       = 1'b0;
    lzs_en     = 1'b0;
    blank_mask = '0;
    blink_mask = '0;
`ifdef SEG7_SCAN_DP_EN
    dp         = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_odat",  32'(odat),  32'h7F);
    check("rst_an",    32'(an),    32'hF);
    check("rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    #1 n_rst = 1'b1;

    // Basic hex scan
    tick(2);
    idat = 16'h12AF; load = 1'b1; tick(1); load = 1'b0;
    tick(3 * FRAME_LEN);

    // Two loads within one frame: last wins, committed at boundary
    idat = 16'h0000; load = 1'b1; tick(1); load = 1'b0;
    tick(3);
    idat = 16'h00C3; load = 1'b1; tick(1); load = 1'b0;
    tick(2 * FRAME_LEN);

    // Leading-zero suppression
    lzs_en = 1'b1;
    idat = 16'h0007; load = 1'b1; tick(1); load = 1'b0;
    tick(2 * FRAME_LEN);
    idat = 16'h0000; load = 1'b1; tick(1); load = 1'b0;
    tick(2 * FRAME_LEN);
    idat = 16'h0500; load = 1'b1; tick(1); load = 1'b0;
    tick(2 * FRAME_LEN);
    lzs_en = 1'b0;

    // Blink and blank masks
    idat = 16'h8888; load = 1'b1; tick(1); load = 1'b0;
    blink_mask = 4'b0010;
    blank_mask = 4'b1000;
    tick(8 * FRAME_LEN);
    blink_mask = '0;
    blank_mask = '0;

    // Load on the frame-pulse cycle goes straight to display
    wait_frame(got_frame);
    #1;
    idat = 16'hBEEF; load = 1'b1; tick(1); load = 1'b0;
    tick(2 * FRAME_LEN);

    // Load held high: display tracks idat once per frame
    load = 1'b1;
    for (int i = 0; i < 3 * FRAME_LEN; i++) begin
      idat = 16'($urandom);
      tick(1);
    end
    load = 1'b0;
    tick(FRAME_LEN);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 24 == 0) begin
        lzs_en     = 1'($urandom);
        blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        blink_mask = 4'($urandom);
      end
      case ($urandom_range(0, 3))
        0:       zmask = 16'hFFFF;
        1:       zmask = 16'h00FF;
        2:       zmask = 16'h000F;
        default: zmask = 16'h0000;
      endcase
      idat = 16'($urandom) & zmask;
      load = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    load       = 1'b0;
    lzs_en     = 1'b0;
    blank_mask = '0;
    blink_mask = '0;
    tick(FRAME_LEN);

    // Asynchronous reset mid-digit with a pending load
    wait_frame(got_frame);
    tick(5);
    idat = 16'h5A5A; load = 1'b1; tick(1); load = 1'b0;
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("arst_odat",  32'(odat),  32'h7F);
    check("arst_an",    32'(an),    32'hF);
    check("arst_frame", 32'(frame), 32'h0);
    tick(3);
    @(negedge clk);
    #1 n_rst = 1'b1;
    tick(3 * FRAME_LEN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
